fifo_stream: RTL and testbench

Parametrised synchronous FIFO with a valid/ready streaming interface on both sides, first-word-fall-through output, live occupancy count, almost-full/almost-empty flags, synchronous flush and a peak-occupancy watermark. It replaces bare read/write-strobe FIFOs between pipeline stages and the memory-request path, where producers need early backpressure hints and debug needs worst-case fill levels. Depth need not be a power of two.

---
 rtl/fifo_stream.sv | 102 ++++++++++
 tb/tb_fifo_stream.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream.sv
// fifo_stream: synchronous valid/ready FIFO with first-word-fall-through output,
// live occupancy, almost-full/almost-empty hints, synchronous flush and a
// peak-occupancy watermark. The depth does not have to be a power of two.
module fifo_stream #(
    parameter int NUM_ENTRIES = 8,
    parameter int DATA_W      = 16,
    parameter int AFULL_TH    = NUM_ENTRIES - 2,
    parameter int AEMPTY_TH   = 1,
    localparam int CNT_W      = $clog2(NUM_ENTRIES + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [CNT_W-1:0]  max_count_o
);

    localparam int ADDR_W = (NUM_ENTRIES > 2) ? $clog2(NUM_ENTRIES) : 1;

    logic [DATA_W-1:0] mem [NUM_ENTRIES];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [CNT_W-1:0]  max_count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    // Pointers wrap explicitly at the last index so non power-of-two depths work.
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] ptr);
        return (ptr == ADDR_W'(NUM_ENTRIES - 1)) ? '0 : ptr + ADDR_W'(1);
    endfunction

    // Handshakes are qualified only by registered occupancy, so a full FIFO
    // refuses a push even when a pop happens in the same cycle.
    assign full  = (count == CNT_W'(NUM_ENTRIES));
    assign empty = (count == '0);
    assign push  = in_valid_i && !full;
    assign pop   = out_ready_i && !empty;

    // Occupancy after this edge, ignoring flush; also feeds the watermark.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Control state: pointers, occupancy and watermark; flush beats everything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            max_count <= '0;
        end else if (flush_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            max_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wrap_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            count <= count_next;
            if (count_next > max_count) begin
                max_count <= count_next;
            end
        end
    end

    // Storage is deliberately not reset; a flush cycle never writes it.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            mem[wr_ptr] <= in_data_i;
        end
    end

    assign in_ready_o     = !full;
    assign out_valid_o    = !empty;
    assign out_data_o     = mem[rd_ptr];
    assign count_o        = count;
    assign max_count_o    = max_count;
    assign almost_full_o  = (count >= CNT_W'(AFULL_TH));
    assign almost_empty_o = (count <= CNT_W'(AEMPTY_TH));

endmodule

// File: tb/tb_fifo_stream.sv
// tb_fifo_stream: drives two fifo_stream instances (depth 8 and depth 5) with the
// same stimulus and scores each against a queue-based reference model.
module tb_fifo_stream;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int N  = (g == 0) ? 8 : 5;
        localparam int CW = $clog2(N + 1);

        logic          in_ready;
        logic          out_valid;
        logic [15:0]   out_data;
        logic [CW-1:0] count;
        logic [CW-1:0] max_count;
        logic          afull;
        logic          aempty;

        logic [15:0] exp_q [$];
        int          model_max = 0;
        bit          do_push;
        bit          do_pop;
        logic [15:0] head;

        fifo_stream #(.NUM_ENTRIES(N), .DATA_W(16)) dut (
            .clk_i          (clk),
            .rst_ni         (rst_n),
            .flush_i        (flush),
            .in_valid_i     (in_valid),
            .in_ready_o     (in_ready),
            .in_data_i      (in_data),
            .out_valid_o    (out_valid),
            .out_ready_i    (out_ready),
            .out_data_o     (out_data),
            .count_o        (count),
            .almost_full_o  (afull),
            .almost_empty_o (aempty),
            .max_count_o    (max_count)
        );

        task automatic checkOutput();
            int sz;
            sz = exp_q.size();
            check($sformatf("d%0d count", N),     int'(count),     sz);
            check($sformatf("d%0d max_count", N), int'(max_count), model_max);
            check($sformatf("d%0d in_ready", N),  int'(in_ready),  (sz != N) ? 1 : 0);
            check($sformatf("d%0d out_valid", N), int'(out_valid), (sz != 0) ? 1 : 0);
            check($sformatf("d%0d afull", N),     int'(afull),     (sz >= N - 2) ? 1 : 0);
            check($sformatf("d%0d aempty", N),    int'(aempty),    (sz <= 1) ? 1 : 0);
        endtask

        // Monitor/scoreboard: compare status, then commit this cycle's transfers.
        always @(negedge clk) begin
            if (!rst_n) begin
                exp_q.delete();
                model_max = 0;
            end
            checkOutput();
            if (rst_n) begin
                if (flush) begin
                    exp_q.delete();
                    model_max = 0;
                end else begin
                    do_push = in_valid && (exp_q.size() < N);
                    do_pop  = out_ready && (exp_q.size() > 0);
                    if (do_pop) begin
                        head = exp_q.pop_front();
                        check($sformatf("d%0d pop data", N), int'(out_data), int'(head));
                    end
                    if (do_push) begin
                        exp_q.push_back(in_data);
                    end
                    if (exp_q.size() > model_max) begin
                        model_max = exp_q.size();
                    end
                end
            end
        end

        // Reset must act immediately, without waiting for a clock edge.
        always @(negedge rst_n) begin
            #1;
            check($sformatf("d%0d rst in_ready", N),  int'(in_ready),  1);
            check($sformatf("d%0d rst out_valid", N), int'(out_valid), 0);
            check($sformatf("d%0d rst count", N),     int'(count),     0);
            check($sformatf("d%0d rst max", N),       int'(max_count), 0);
            check($sformatf("d%0d rst afull", N),     int'(afull),     0);
            check($sformatf("d%0d rst aempty", N),    int'(aempty),    1);
        end
    end

    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    // Directed scenarios followed by a randomized phase.
    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n  = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

        // Fill with 1..8 while the consumer stalls.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 16'(i), 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

        // Full: push and pop together, only the pop may happen.
        applyStimulus(1'b1, 16'h00AA, 1'b1, 1'b0);

        // Drain everything.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        end

        // Empty: push and pop together, only the push may happen.
        applyStimulus(1'b1, 16'h1234, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

        // Flush with a coincident push, then 0xBEEF must come out first.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'(16'h0050 + i), 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 16'hDEAD, 1'b1, 1'b1);
        applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hC0DE, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

        // Continuous streaming exercises pointer wrap on both depths.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 16'(16'h0100 + i), 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom()),
                          ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1,
                          ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < 200; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 16'($urandom()),
                          1'($urandom_range(0, 1)), 1'b0);
        end

        // Asynchronous reset between edges while a stream is active.
        applyStimulus(1'b1, 16'h0A0A, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0B0B, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(1'b1, 16'h3001, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h3002, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h3003, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
